// File: rtl/edit_pkg.sv
// Shared types and constants for the clock edit front-end: screen codes,
// sequencer states, cursor ranges and the auto-repeat step function.
package edit_pkg;

    typedef enum logic [1:0] {
        SCR_TIME = 2'd0,
        SCR_DATE = 2'd1,
        SCR_TZ   = 2'd2,
        SCR_SW   = 2'd3
    } screen_e;

    typedef enum logic [1:0] {
        ST_VIEW,
        ST_MODE_HELD,
        ST_EDIT,
        ST_EDIT_MODE_HELD
    } state_e;

    // Indexed by screen code; the stopwatch entries are never used.
    localparam logic [3:0][2:0] POS_FIRST = {3'd0, 3'd2, 3'd0, 3'd0};
    localparam logic [3:0][2:0] POS_LAST  = {3'd0, 3'd5, 3'd7, 3'd5};

    localparam int unsigned BTN_MODE  = 0;
    localparam int unsigned BTN_SEL   = 1;
    localparam int unsigned BTN_PLUS  = 2;
    localparam int unsigned BTN_MINUS = 3;

    typedef struct packed {
        logic        fire;
        logic        armed;
        logic        rep_on;
        logic [31:0] cnt;
    } rep_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One key's repeat engine; cnt holds cycles since the last strobe.
    function automatic rep_s rep_next(input rep_s        cur,
                                      input logic        run,
                                      input logic        held,
                                      input logic        press,
                                      input logic [31:0] delay,
                                      input logic [31:0] rate);
        rep_s nxt;
        nxt      = cur;
        nxt.fire = 1'b0;
        if (!run || !held) begin
            nxt.armed  = 1'b0;
            nxt.rep_on = 1'b0;
            nxt.cnt    = '0;
        end else if (press) begin
            nxt.fire   = 1'b1;
            nxt.armed  = 1'b1;
            nxt.rep_on = 1'b0;
            nxt.cnt    = 32'd1;
        end else if (cur.armed) begin
            if ((!cur.rep_on && cur.cnt >= delay) || (cur.rep_on && cur.cnt >= rate)) begin
                nxt.fire   = 1'b1;
                nxt.rep_on = 1'b1;
                nxt.cnt    = 32'd1;
            end else begin
                nxt.cnt = sat_inc(cur.cnt);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/edit_controller_if.sv
// Button inputs and counter-control outputs of the edit front-end.
interface edit_controller_if;
    logic       ClkSecond;
    logic       BtnMode;
    logic       BtnSel;
    logic       BtnPlus;
    logic       BtnMinus;
    logic [1:0] screen;
    logic       EditMode;
    logic [2:0] EditPos;
    logic       KeyPlus;
    logic       KeyMinus;

    modport master (
        output ClkSecond, BtnMode, BtnSel, BtnPlus, BtnMinus,
        input  screen, EditMode, EditPos, KeyPlus, KeyMinus
    );

    modport slave (
        input  ClkSecond, BtnMode, BtnSel, BtnPlus, BtnMinus,
        output screen, EditMode, EditPos, KeyPlus, KeyMinus
    );
endinterface

// File: rtl/key_debouncer.sv
// Synchronises one active-low raw button and filters it into a held level
// plus a one-cycle press event aligned with the level change.
module key_debouncer #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic held_o,
    output logic press_evt_o
);

    logic [1:0]  sync_q;
    logic        level_q, level_d;
    logic [15:0] cnt_q, cnt_d;
    logic        press_q;

    // NOTE: defaults first in always_comb so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q >= DEB_CYCLES - 16'd1) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= level_q & ~level_d;
        end
    end

    assign held_o      = ~level_q;
    assign press_evt_o = press_q;

endmodule

// File: rtl/edit_controller.sv
// Turns four raw buttons into screen selection, edit cursor and registered
// active-low increment/decrement strobes for the clock counters.
module edit_controller
    import edit_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES  = 16'd50000,
    parameter logic [31:0] LONG_CYCLES = 32'd50000000,
    parameter logic [31:0] REP_DELAY   = 32'd25000000,
    parameter logic [31:0] REP_RATE    = 32'd5000000,
    parameter logic [7:0]  TIMEOUT_S   = 8'd10
) (
    input  logic              clk,
    input  logic              reset,
    edit_controller_if.slave  bus
);

    logic [3:0]  btn_n, held, press;
    logic [3:0]  held_prev_q;
    state_e      state_q, state_d;
    screen_e     screen_q, screen_d;
    logic        edit_mode_q, edit_mode_d;
    logic [2:0]  edit_pos_q, edit_pos_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]  idle_q, idle_d;
    rep_s        plus_q, plus_d, minus_q, minus_d;
    logic        activity, timeout_hit, key_run;

    assign btn_n = {bus.BtnMinus, bus.BtnPlus, bus.BtnSel, bus.BtnMode};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk         (clk),
            .reset       (reset),
            .btn_n_i     (btn_n[g]),
            .held_o      (held[g]),
            .press_evt_o (press[g])
        );
    end

    assign activity    = |(held ^ held_prev_q);
    assign timeout_hit = (state_q == ST_EDIT) && bus.ClkSecond &&
                         ({1'b0, idle_q} + 9'd1 >= {1'b0, TIMEOUT_S});
    assign key_run     = (state_q == ST_EDIT) && !timeout_hit &&
                         !(held[BTN_PLUS] && held[BTN_MINUS]);

    assign plus_d  = rep_next(plus_q,  key_run, held[BTN_PLUS],  press[BTN_PLUS],  REP_DELAY, REP_RATE);
    assign minus_d = rep_next(minus_q, key_run, held[BTN_MINUS], press[BTN_MINUS], REP_DELAY, REP_RATE);

    always_comb begin
        state_d     = state_q;
        screen_d    = screen_q;
        edit_mode_d = edit_mode_q;
        edit_pos_d  = edit_pos_q;
        hold_cnt_d  = hold_cnt_q;
        idle_d      = idle_q;

        if (activity || !(state_q inside {ST_EDIT, ST_EDIT_MODE_HELD})) begin
            idle_d = '0;
        end else if (state_q == ST_EDIT && bus.ClkSecond && idle_q != 8'hFF) begin
            idle_d = idle_q + 8'd1;
        end

        unique case (state_q)
            ST_VIEW: begin
                if (press[BTN_MODE]) begin
                    state_d    = ST_MODE_HELD;
                    hold_cnt_d = '0;
                end
            end
            ST_MODE_HELD: begin
                hold_cnt_d = sat_inc(hold_cnt_q);
                if (!held[BTN_MODE]) begin
                    screen_d = screen_e'(screen_q + 2'd1);
                    state_d  = ST_VIEW;
                end else if (screen_q != SCR_SW && sat_inc(hold_cnt_q) >= LONG_CYCLES) begin
                    state_d     = ST_EDIT;
                    edit_mode_d = 1'b1;
                    edit_pos_d  = POS_FIRST[screen_q];
                end
            end
            ST_EDIT: begin
                if (timeout_hit) begin
                    state_d     = ST_VIEW;
                    edit_mode_d = 1'b0;
                    edit_pos_d  = '0;
                end else if (press[BTN_MODE]) begin
                    state_d = ST_EDIT_MODE_HELD;
                end else if (press[BTN_SEL]) begin
                    edit_pos_d = (edit_pos_q == POS_LAST[screen_q]) ? POS_FIRST[screen_q]
                                                                    : edit_pos_q + 3'd1;
                end
            end
            ST_EDIT_MODE_HELD: begin
                if (!held[BTN_MODE]) begin
                    state_d     = ST_VIEW;
                    edit_mode_d = 1'b0;
                    edit_pos_d  = '0;
                end
            end
            default: state_d = ST_VIEW;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_VIEW;
            screen_q    <= SCR_TIME;
            edit_mode_q <= 1'b0;
            edit_pos_q  <= '0;
            hold_cnt_q  <= '0;
            idle_q      <= '0;
            held_prev_q <= '0;
            plus_q      <= '0;
            minus_q     <= '0;
        end else begin
            state_q     <= state_d;
            screen_q    <= screen_d;
            edit_mode_q <= edit_mode_d;
            edit_pos_q  <= edit_pos_d;
            hold_cnt_q  <= hold_cnt_d;
            idle_q      <= idle_d;
            held_prev_q <= held;
            plus_q      <= plus_d;
            minus_q     <= minus_d;
        end
    end

    assign bus.screen   = screen_q;
    assign bus.EditMode = edit_mode_q;
    assign bus.EditPos  = edit_pos_q;
    assign bus.KeyPlus  = ~plus_q.fire;
    assign bus.KeyMinus = ~minus_q.fire;

endmodule

// File: tb/tb_edit_controller.sv
// Directed bench for edit_controller with shortened timing parameters.
module tb_edit_controller;

    localparam int MODE  = 0;
    localparam int SEL   = 1;
    localparam int PLUS  = 2;
    localparam int MINUS = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    edit_controller_if bus ();

    edit_controller #(
        .DEB_CYCLES  (16'd4),
        .LONG_CYCLES (32'd20),
        .REP_DELAY   (32'd30),
        .REP_RATE    (32'd10),
        .TIMEOUT_S   (8'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int plus_pulses = 0, minus_pulses = 0, plus_wide = 0, minus_wide = 0, both_low = 0;
    int plus_start[$];
    logic plus_prev = 1'b1, minus_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (bus.KeyPlus === 1'b0) begin
            if (plus_prev) begin
                plus_pulses++;
                plus_start.push_back(cyc);
            end else begin
                plus_wide++;
            end
        end
        if (bus.KeyMinus === 1'b0) begin
            if (minus_prev) minus_pulses++;
            else            minus_wide++;
        end
        if (bus.KeyPlus === 1'b0 && bus.KeyMinus === 1'b0) both_low++;
        plus_prev  = (bus.KeyPlus  !== 1'b0);
        minus_prev = (bus.KeyMinus !== 1'b0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            MODE:    bus.BtnMode  = v;
            SEL:     bus.BtnSel   = v;
            PLUS:    bus.BtnPlus  = v;
            default: bus.BtnMinus = v;
        endcase
    endtask

    task automatic tap(input int which, input int hold, input int gap);
        set_btn(which, 1'b0);
        step(hold);
        set_btn(which, 1'b1);
        step(gap);
    endtask

    task automatic clear_pulses();
        plus_pulses  = 0;
        minus_pulses = 0;
        plus_wide    = 0;
        minus_wide   = 0;
        plus_start.delete();
    endtask

    task automatic enter_edit(input logic [2:0] exp_pos);
        int n = 0;
        set_btn(MODE, 1'b0);
        while (bus.EditMode !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        checks++;
        if (n > 30) begin
            errors++;
            $display("FAIL edit_entry: EditMode=%b after %0d cycles, required 1 within 30", bus.EditMode, n);
        end
        checks++;
        if (bus.EditPos !== exp_pos) begin
            errors++;
            $display("FAIL edit_entry_pos: EditPos=%0d, required %0d", bus.EditPos, exp_pos);
        end
        if (n < 40) step(40 - n);
        set_btn(MODE, 1'b1);
        step(12);
        checks++;
        if (bus.EditMode !== 1'b1) begin
            errors++;
            $display("FAIL edit_release_ignored: EditMode=%b, required 1", bus.EditMode);
        end
    endtask

    task automatic test_reset();
        bus.ClkSecond = 1'b0;
        bus.BtnMode = 1'b1; bus.BtnSel = 1'b1; bus.BtnPlus = 1'b1; bus.BtnMinus = 1'b1;
        reset = 1'b1;
        step(3);
        checks++;
        if (bus.screen !== 2'd0) begin errors++; $display("FAIL reset_screen: got %0d, required 0", bus.screen); end
        checks++;
        if (bus.EditMode !== 1'b0) begin errors++; $display("FAIL reset_editmode: got %b, required 0", bus.EditMode); end
        checks++;
        if (bus.EditPos !== 3'd0) begin errors++; $display("FAIL reset_editpos: got %0d, required 0", bus.EditPos); end
        checks++;
        if (bus.KeyPlus !== 1'b1 || bus.KeyMinus !== 1'b1) begin
            errors++;
            $display("FAIL reset_keys: KeyPlus=%b KeyMinus=%b, required 1 1", bus.KeyPlus, bus.KeyMinus);
        end
        @(negedge clk);
        reset = 1'b0;
        step(3);
    endtask

    task automatic test_screen_cycle();
        logic [1:0] exp_scr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        clear_pulses();
        for (int i = 0; i < 4; i++) begin
            tap(MODE, 10, 12);
            checks++;
            if (bus.screen !== exp_scr[i]) begin
                errors++;
                $display("FAIL screen_tap%0d: screen=%0d, required %0d", i, bus.screen, exp_scr[i]);
            end
            checks++;
            if (bus.EditMode !== 1'b0) begin
                errors++;
                $display("FAIL screen_tap%0d_editmode: EditMode=%b, required 0", i, bus.EditMode);
            end
        end
        checks++;
        if (plus_pulses != 0 || minus_pulses != 0) begin
            errors++;
            $display("FAIL view_no_strobe: plus=%0d minus=%0d pulses, required 0 0", plus_pulses, minus_pulses);
        end
    endtask

    task automatic test_edit_cursor();
        logic [2:0] exp_pos [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        enter_edit(3'd0);
        for (int i = 0; i < 6; i++) begin
            tap(SEL, 8, 10);
            checks++;
            if (bus.EditPos !== exp_pos[i]) begin
                errors++;
                $display("FAIL sel_tap%0d: EditPos=%0d, required %0d", i, bus.EditPos, exp_pos[i]);
            end
        end
        tap(MODE, 10, 12);
        checks++;
        if (bus.EditMode !== 1'b0 || bus.EditPos !== 3'd0 || bus.screen !== 2'd0) begin
            errors++;
            $display("FAIL edit_exit: EditMode=%b EditPos=%0d screen=%0d, required 0 0 0",
                     bus.EditMode, bus.EditPos, bus.screen);
        end
    endtask

    task automatic test_repeat();
        tap(MODE, 10, 12);
        tap(MODE, 10, 12);
        checks++;
        if (bus.screen !== 2'd2) begin errors++; $display("FAIL tz_screen: screen=%0d, required 2", bus.screen); end
        enter_edit(3'd2);
        clear_pulses();
        set_btn(PLUS, 1'b0);
        step(48);
        set_btn(PLUS, 1'b1);
        step(20);
        checks++;
        if (plus_pulses != 3) begin errors++; $display("FAIL repeat_count: %0d pulses, required 3", plus_pulses); end
        checks++;
        if (plus_wide != 0) begin errors++; $display("FAIL repeat_width: %0d extra low cycles, required 0", plus_wide); end
        checks++;
        if (plus_start.size() < 3) begin
            errors++;
            $display("FAIL repeat_spacing: only %0d pulses recorded, required 3", plus_start.size());
        end else if (plus_start[1] - plus_start[0] != 30 || plus_start[2] - plus_start[1] != 10) begin
            errors++;
            $display("FAIL repeat_spacing: gaps %0d %0d, required 30 10",
                     plus_start[1] - plus_start[0], plus_start[2] - plus_start[1]);
        end
        checks++;
        if (minus_pulses != 0) begin errors++; $display("FAIL repeat_minus_quiet: %0d pulses, required 0", minus_pulses); end
    endtask

    task automatic test_both_held();
        clear_pulses();
        bus.BtnPlus  = 1'b0;
        bus.BtnMinus = 1'b0;
        step(60);
        bus.BtnPlus  = 1'b1;
        bus.BtnMinus = 1'b1;
        step(15);
        checks++;
        if (plus_pulses != 0 || minus_pulses != 0) begin
            errors++;
            $display("FAIL both_held: plus=%0d minus=%0d pulses, required 0 0", plus_pulses, minus_pulses);
        end
        tap(MINUS, 8, 12);
        checks++;
        if (minus_pulses != 1 || minus_wide != 0) begin
            errors++;
            $display("FAIL minus_tap: %0d pulses %0d extra low cycles, required 1 0", minus_pulses, minus_wide);
        end
    endtask

    task automatic test_timeout();
        step(5);
        for (int i = 0; i < 2; i++) begin
            bus.ClkSecond = 1'b1;
            step(1);
            bus.ClkSecond = 1'b0;
            step(4);
        end
        checks++;
        if (bus.EditMode !== 1'b1) begin errors++; $display("FAIL timeout_early: EditMode=%b, required 1", bus.EditMode); end
        bus.ClkSecond = 1'b1;
        step(1);
        bus.ClkSecond = 1'b0;
        checks++;
        if (bus.EditMode !== 1'b0 || bus.EditPos !== 3'd0 || bus.screen !== 2'd2) begin
            errors++;
            $display("FAIL timeout_exit: EditMode=%b EditPos=%0d screen=%0d, required 0 0 2",
                     bus.EditMode, bus.EditPos, bus.screen);
        end
        step(5);
    endtask

    task automatic test_bounce();
        enter_edit(3'd2);
        clear_pulses();
        for (int i = 0; i < 6; i++) begin
            bus.BtnPlus = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        bus.BtnPlus = 1'b1;
        step(15);
        checks++;
        if (plus_pulses != 0) begin errors++; $display("FAIL bounce: %0d pulses, required 0", plus_pulses); end
        tap(MODE, 10, 12);
        checks++;
        if (bus.EditMode !== 1'b0) begin errors++; $display("FAIL bounce_exit: EditMode=%b, required 0", bus.EditMode); end
        tap(PLUS, 8, 12);
        checks++;
        if (plus_pulses != 0) begin errors++; $display("FAIL view_plus: %0d pulses, required 0", plus_pulses); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        enter_edit(3'd2);
        bus.BtnMinus = 1'b0;
        while (bus.KeyMinus !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.KeyMinus !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_strobe: KeyMinus=%b after %0d cycles, required 0", bus.KeyMinus, n);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.KeyMinus !== 1'b1 || bus.EditMode !== 1'b0 || bus.screen !== 2'd0 || bus.EditPos !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: KeyMinus=%b EditMode=%b screen=%0d EditPos=%0d, required 1 0 0 0",
                     bus.KeyMinus, bus.EditMode, bus.screen, bus.EditPos);
        end
        bus.BtnMinus = 1'b1;
        step(3);
        @(negedge clk);
        reset = 1'b0;
        step(3);
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_low != 0) begin
            errors++;
            $display("FAIL key_exclusive: %0d cycles with both strobes low, required 0", both_low);
        end
    endtask

    initial begin
        test_reset();
        test_screen_cycle();
        test_edit_cursor();
        test_repeat();
        test_both_held();
        test_timeout();
        test_bounce();
        test_reset_mid();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
